// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer handlers:
//   PTRWIDTH_DEF : default address width (depth = 2**PTRWIDTH_DEF)
//   PTR_W        : pointer width including the extra wrap bit
//   ptr_t        : pointer type at the default width
//   bin2gray     : binary -> reflected Gray code
//   gray2bin     : reflected Gray code -> binary
// The conversion functions work on a 32-bit container. A narrower pointer is
// zero-extended on the way in and truncated on the way out. Leading zeros do
// not change either conversion.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int PTRWIDTH_DEF = 3;
    localparam int PTR_W        = PTRWIDTH_DEF + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Both flops clear on an asynchronous active-high reset.
// Ports:
//   i_clk : destination-domain clock
//   i_rst : asynchronous active-high reset
//   i_d   : WIDTH-bit Gray pointer from the source domain
//   o_q   : synchronised pointer, two destination clocks late
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule

// File: rtl/read_pointer_handler.sv
// ---------------------------------------------------------------------------
// read_pointer_handler
// Read-domain pointer and status logic for an asynchronous FIFO. This block:
//   - synchronises the write Gray pointer into rclk,
//   - keeps the binary and Gray read pointers,
//   - registers empty, the read-side fill level and a read-underflow pulse.
// Optional build macro: ALMOST_EMPTY_EN adds the almost_empty output and the
// AE_THRESH parameter.
// Ports:
//   rclk         : read clock
//   rrst         : asynchronous active-high reset
//   r_en         : read request
//   g_wptr       : write Gray pointer, unsynchronised, from the wclk domain
//   b_rptr       : binary read pointer; its low PTRWIDTH bits are the RAM address
//   g_rptr       : registered Gray read pointer, sent to the write side
//   empty        : registered empty flag
//   rlevel       : registered occupancy seen from the read side (0..2**PTRWIDTH)
//   rd_err       : one-cycle pulse when r_en is sampled while empty
//   almost_empty : rlevel <= AE_THRESH (ALMOST_EMPTY_EN builds only)
// ---------------------------------------------------------------------------
module read_pointer_handler
    import fifo_pkg::*;
#(
    parameter int PTRWIDTH = PTRWIDTH_DEF
`ifdef ALMOST_EMPTY_EN
    ,
    parameter int AE_THRESH = 1
`endif
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                r_en,
    input  logic [PTRWIDTH:0]   g_wptr,
    output logic [PTRWIDTH:0]   b_rptr,
    output logic [PTRWIDTH:0]   g_rptr,
    output logic                empty,
    output logic [PTRWIDTH:0]   rlevel,
    output logic                rd_err
`ifdef ALMOST_EMPTY_EN
    ,
    output logic                almost_empty
`endif
);

    localparam int PW = PTRWIDTH + 1;

    logic [PW-1:0] r_b_rptr;
    logic [PW-1:0] r_g_rptr;
    logic          r_empty;
    logic [PW-1:0] r_rlevel;
    logic          r_rd_err;

    logic          w_rd_ok;
    logic [PW-1:0] w_b_next;
    logic [PW-1:0] w_g_next;
    logic [PW-1:0] w_g_wptr_sync;
    logic [PW-1:0] w_b_wptr_s;
    logic [PW-1:0] w_level_next;

    sync_2ff #(
        .WIDTH (PW)
    ) u_sync_wptr (
        .i_clk (rclk),
        .i_rst (rrst),
        .i_d   (g_wptr),
        .o_q   (w_g_wptr_sync)
    );

    // A read is only accepted when not empty, so the pointer can never pass
    // the synchronised write pointer.
    assign w_rd_ok      = r_en & ~r_empty;
    assign w_b_next     = r_b_rptr + {{(PW-1){1'b0}}, w_rd_ok};
    assign w_g_next     = PW'(bin2gray(32'(w_b_next)));
    assign w_b_wptr_s   = PW'(gray2bin(32'(w_g_wptr_sync)));
    // The wrap bit makes a completely full FIFO (2**PTRWIDTH) representable.
    assign w_level_next = w_b_wptr_s - w_b_next;

    // empty and rlevel use the next pointer, so the read that drains the
    // FIFO raises empty on the same edge that accepts it.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_b_rptr <= '0;
            r_g_rptr <= '0;
            r_empty  <= 1'b1;
            r_rlevel <= '0;
            r_rd_err <= 1'b0;
        end else begin
            r_b_rptr <= w_b_next;
            r_g_rptr <= w_g_next;
            r_empty  <= (w_g_next == w_g_wptr_sync);
            r_rlevel <= w_level_next;
            r_rd_err <= r_en & r_empty;
        end
    end

    assign b_rptr = r_b_rptr;
    assign g_rptr = r_g_rptr;
    assign empty  = r_empty;
    assign rlevel = r_rlevel;
    assign rd_err = r_rd_err;

`ifdef ALMOST_EMPTY_EN
    logic r_almost_empty;
    logic w_ae_next;

    assign w_ae_next = ({{(32-PW){1'b0}}, w_level_next} <= $unsigned(AE_THRESH));

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_empty <= w_ae_next;
        end
    end

    assign almost_empty = r_almost_empty;
`endif

endmodule

// File: tb/tb_read_pointer_handler.sv
// ---------------------------------------------------------------------------
// tb_read_pointer_handler
// Directed bench for read_pointer_handler at PTRWIDTH=3.
// ---------------------------------------------------------------------------
module tb_read_pointer_handler;

    logic       rclk;
    logic       rrst;
    logic       r_en;
    logic [3:0] g_wptr;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       empty;
    logic [3:0] rlevel;
    logic       rd_err;
`ifdef ALMOST_EMPTY_EN
    logic       almost_empty;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    read_pointer_handler #(
        .PTRWIDTH (3)
    ) dut (
        .rclk   (rclk),
        .rrst   (rrst),
        .r_en   (r_en),
        .g_wptr (g_wptr),
        .b_rptr (b_rptr),
        .g_rptr (g_rptr),
        .empty  (empty),
        .rlevel (rlevel),
        .rd_err (rd_err)
`ifdef ALMOST_EMPTY_EN
        ,
        .almost_empty (almost_empty)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [3:0] gray4(input int k);
        logic [3:0] b;
        b = 4'(k);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rclk edge and settle just after it.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        rrst   = 1'b1;
        r_en   = 1'b0;
        g_wptr = 4'b0000;
        #2;
        check("rst_b_rptr", 32'(b_rptr), 32'h0);
        check("rst_g_rptr", 32'(g_rptr), 32'h0);
        check("rst_empty",  32'(empty),  32'h1);
        check("rst_rlevel", 32'(rlevel), 32'h0);
        check("rst_rd_err", 32'(rd_err), 32'h0);
`ifdef ALMOST_EMPTY_EN
        check("rst_almost_empty", 32'(almost_empty), 32'h1);
`endif
        tick();
        tick();
        rrst = 1'b0;
        tick();

        // Write pointer 0 -> 1, visible two edges later.
        g_wptr = 4'b0001;
        tick();
        check("lat_empty_N", 32'(empty), 32'h1);
        tick();
        check("lat_empty_N1", 32'(empty), 32'h1);
        tick();
        check("lat_empty_N2",  32'(empty),  32'h0);
        check("lat_rlevel_N2", 32'(rlevel), 32'h1);

        // Occupancy 3, then three reads drain it.
        g_wptr = 4'b0010;
        tick();
        tick();
        tick();
        check("c_rlevel3", 32'(rlevel), 32'h3);
        check("c_empty0",  32'(empty),  32'h0);
        r_en = 1'b1;
        tick();
        check("c_rd1_b", 32'(b_rptr), 32'h1);
        check("c_rd1_g", 32'(g_rptr), 32'b0001);
        check("c_rd1_lvl", 32'(rlevel), 32'h2);
        tick();
        check("c_rd2_b", 32'(b_rptr), 32'h2);
        check("c_rd2_g", 32'(g_rptr), 32'b0011);
        tick();
        check("c_rd3_b", 32'(b_rptr), 32'h3);
        check("c_rd3_g", 32'(g_rptr), 32'b0010);
        check("c_rd3_empty", 32'(empty), 32'h1);
        check("c_rd3_err", 32'(rd_err), 32'h0);
        tick();
        check("c_rd4_err", 32'(rd_err), 32'h1);
        check("c_rd4_b",   32'(b_rptr), 32'h3);
        r_en = 1'b0;
        tick();
        check("c_err_pulse_end", 32'(rd_err), 32'h0);

        // Reset asserted between edges while a read is in progress.
        g_wptr = 4'b0110;
        tick();
        g_wptr = 4'b0111;
        tick();
        tick();
        tick();
        r_en = 1'b1;
        tick();
        check("d_pre_b", 32'(b_rptr), 32'h4);
        rrst = 1'b1;
        #1;
        check("d_async_b",     32'(b_rptr), 32'h0);
        check("d_async_g",     32'(g_rptr), 32'h0);
        check("d_async_empty", 32'(empty),  32'h1);
        check("d_async_lvl",   32'(rlevel), 32'h0);
        r_en   = 1'b0;
        g_wptr = 4'b0000;
        tick();
        tick();
        rrst = 1'b0;
        tick();

        // Preload one full lap with 8 writes and 8 reads.
        r_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            g_wptr = gray4(k);
            tick();
        end
        for (int k = 0; k < 8; k++) tick();
        r_en = 1'b0;
        tick();
        check("e_lap_b",     32'(b_rptr), 32'b1000);
        check("e_lap_g",     32'(g_rptr), 32'b1100);
        check("e_lap_empty", 32'(empty),  32'h1);
        for (int k = 9; k <= 12; k++) begin
            g_wptr = gray4(k);
            tick();
        end
        tick();
        tick();
        tick();
        check("e_wrap_lvl",   32'(rlevel), 32'h4);
        check("e_wrap_empty", 32'(empty),  32'h0);
        r_en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        r_en = 1'b0;
        check("e_wrap_b",     32'(b_rptr), 32'b1100);
        check("e_wrap_g",     32'(g_rptr), 32'b1010);
        check("e_wrap_empty1", 32'(empty), 32'h1);
        check("e_wrap_lvl0",  32'(rlevel), 32'h0);

        // Full view from the read side.
        rrst   = 1'b1;
        g_wptr = 4'b0000;
        tick();
        tick();
        rrst = 1'b0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            g_wptr = gray4(k);
            tick();
        end
        tick();
        tick();
        tick();
        check("f_full_lvl",   32'(rlevel), 32'h8);
        check("f_full_empty", 32'(empty),  32'h0);
        check("f_full_b",     32'(b_rptr), 32'h0);
`ifdef ALMOST_EMPTY_EN
        check("f_full_ae", 32'(almost_empty), 32'h0);
`endif
        r_en = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        r_en = 1'b0;
        check("f_lvl2", 32'(rlevel), 32'h2);
`ifdef ALMOST_EMPTY_EN
        check("f_lvl2_ae", 32'(almost_empty), 32'h0);
`endif
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("f_lvl1",       32'(rlevel), 32'h1);
        check("f_lvl1_empty", 32'(empty),  32'h0);
`ifdef ALMOST_EMPTY_EN
        check("f_lvl1_ae", 32'(almost_empty), 32'h1);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
